// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the core's unified memory port: fetch and load/store
// share one registered memory handshake, round-robin on ties, with a response budget.
module mem_port_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        timeout_error,
  output logic [1:0]  current_state_vector,
  output logic [1:0]  grant_vector
);

  localparam int CW        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wstrb_q, mem_wstrb_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          if_done_q, if_done_d;
  logic          d_done_q, d_done_d;
  logic          timeout_error_q, timeout_error_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_grant_q, last_grant_d;   // 1 = data was granted last
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pick_data;
  logic          timeout_hit;
  logic          finish;

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_d         = state_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wstrb_d     = mem_wstrb_q;
    if_rdata_d      = if_rdata_q;
    d_rdata_d       = d_rdata_q;
    if_done_d       = 1'b0;
    d_done_d        = 1'b0;
    timeout_error_d = timeout_error_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    cnt_d           = cnt_q;
    pick_data       = 1'b0;
    finish          = 1'b0;

    // The budget is spent when the current BUSY cycle is the TIMEOUT-th one.
    if ((TIMEOUT != 0) && (cnt_q >= TO_LAST)) begin
      timeout_hit = 1'b1;
    end else begin
      timeout_hit = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        grant_d   = 2'b00;
        mem_req_d = 1'b0;
        if (if_req || d_req) begin
          if (if_req && d_req) begin
            pick_data = ~last_grant_q;
          end else begin
            pick_data = d_req;
          end
          if (pick_data) begin
            mem_we_d     = d_we;
            mem_addr_d   = d_addr;
            mem_wdata_d  = d_wdata;
            mem_wstrb_d  = d_wstrb;
            grant_d      = 2'b10;
            last_grant_d = 1'b1;
          end else begin
            mem_we_d     = 1'b0;
            mem_addr_d   = if_addr;
            mem_wdata_d  = 32'h0000_0000;
            mem_wstrb_d  = 4'b0000;
            grant_d      = 2'b01;
            last_grant_d = 1'b0;
          end
          cnt_d     = CW'(0);
          mem_req_d = 1'b1;
          state_d   = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        mem_req_d = 1'b1;
        if (mem_ready) begin
          finish = 1'b1;
          if (grant_q[1]) begin
            d_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
        end else if (timeout_hit) begin
          finish          = 1'b1;
          timeout_error_d = 1'b1;
          if (grant_q[1]) begin
            d_rdata_d = 32'h0000_0000;
          end else begin
            if_rdata_d = 32'h0000_0000;
          end
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end
        if (finish) begin
          mem_req_d = 1'b0;
          if_done_d = grant_q[0];
          d_done_d  = grant_q[1];
          state_d   = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        mem_req_d = 1'b0;
        grant_d   = 2'b00;
        state_d   = ST_IDLE;
      end
      default: begin
        mem_req_d = 1'b0;
        grant_d   = 2'b00;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops mem_req immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= 32'h0000_0000;
      mem_wdata_q     <= 32'h0000_0000;
      mem_wstrb_q     <= 4'b0000;
      if_rdata_q      <= 32'h0000_0000;
      d_rdata_q       <= 32'h0000_0000;
      if_done_q       <= 1'b0;
      d_done_q        <= 1'b0;
      timeout_error_q <= 1'b0;
      grant_q         <= 2'b00;
      last_grant_q    <= 1'b1;
      cnt_q           <= CW'(0);
    end else begin
      state_q         <= state_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wstrb_q     <= mem_wstrb_d;
      if_rdata_q      <= if_rdata_d;
      d_rdata_q       <= d_rdata_d;
      if_done_q       <= if_done_d;
      d_done_q        <= d_done_d;
      timeout_error_q <= timeout_error_d;
      grant_q         <= grant_d;
      last_grant_q    <= last_grant_d;
      cnt_q           <= cnt_d;
    end
  end

  assign mem_req              = mem_req_q;
  assign mem_we               = mem_we_q;
  assign mem_addr             = mem_addr_q;
  assign mem_wdata            = mem_wdata_q;
  assign mem_wstrb            = mem_wstrb_q;
  assign if_rdata             = if_rdata_q;
  assign d_rdata              = d_rdata_q;
  assign if_done              = if_done_q;
  assign d_done               = d_done_q;
  assign timeout_error        = timeout_error_q;
  assign grant_vector         = grant_q;
  assign current_state_vector = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4): expected completions are queued
// when a request is driven and compared when the matching done pulse appears.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        timeout_error;
  logic [1:0]  current_state_vector;
  logic [1:0]  grant_vector;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_error(timeout_error), .current_state_vector(current_state_vector),
    .grant_vector(grant_vector)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a done pulse, then compare it with the oldest queued expectation.
  task automatic pop_check(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!(if_done || d_done) && n < 50) begin
      cyc();
      n++;
    end
    chk({tag, "_done_seen"}, {31'd0, (n < 50)}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_who"}, {30'd0, d_done, if_done}, e.is_data ? 32'd2 : 32'd1);
      chk({tag, "_rdata"}, e.is_data ? d_rdata : if_rdata, e.rdata);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},  {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_we"},   {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"},  d_rdata, 32'd0);
    chk({tag, "_dones"},    {30'd0, d_done, if_done}, 32'd0);
    chk({tag, "_tmo"},      {31'd0, timeout_error}, 32'd0);
    chk({tag, "_grant"},    {30'd0, grant_vector}, 32'd0);
    chk({tag, "_state"},    {30'd0, current_state_vector}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0; mem_rdata = 32'd0; mem_ready = 1'b0;
    cyc(); cyc();
    chk_all_zero("reset");
    rst = 1'b0;
    cyc();

    // Single fetch, ready on first BUSY cycle.
    if_req = 1'b1; if_addr = 32'h0000_0010;
    sb.push_back('{1'b0, 32'h0051_3093});
    cyc();
    chk("f1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("f1_mem_addr", mem_addr, 32'h0000_0010);
    chk("f1_mem_we", {31'd0, mem_we}, 32'd0);
    chk("f1_grant", {30'd0, grant_vector}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h0051_3093;
    cyc();
    chk("f1_if_done_cyc2", {31'd0, if_done}, 32'd1);
    chk("f1_grant_done", {30'd0, grant_vector}, 32'd1);
    chk("f1_mem_req_done", {31'd0, mem_req}, 32'd0);
    if_req = 1'b0; mem_ready = 1'b0;
    pop_check("f1");
    cyc();
    chk("f1_idle_state", {30'd0, current_state_vector}, 32'd0);
    chk("f1_idle_grant", {30'd0, grant_vector}, 32'd0);
    chk("f1_pulse_once", {31'd0, if_done}, 32'd0);

    // Store with 3 wait cycles; ready on the 4th BUSY cycle.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hCAFE_F00D; d_wstrb = 4'b0011;
    sb.push_back('{1'b1, 32'h5555_AAAA});
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("st_mem_req", {31'd0, mem_req}, 32'd1);
      chk("st_mem_we", {31'd0, mem_we}, 32'd1);
      chk("st_mem_addr", mem_addr, 32'h0000_0100);
      chk("st_mem_wdata", mem_wdata, 32'hCAFE_F00D);
      chk("st_mem_wstrb", {28'd0, mem_wstrb}, 32'd3);
      chk("st_state_busy", {30'd0, current_state_vector}, 32'd1);
      d_addr = 32'hFFFF_FFFF; d_wdata = 32'h0; d_wstrb = 4'b1111;
      if (i == 3) begin
        mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
      end
      cyc();
    end
    chk("st_d_done", {31'd0, d_done}, 32'd1);
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    pop_check("st");
    chk("st_no_tmo", {31'd0, timeout_error}, 32'd0);
    cyc();
    chk("st_pulse_once", {31'd0, d_done}, 32'd0);

    // Load with ready on the cycle the timeout would fire.
    d_req = 1'b1; d_addr = 32'h0000_0200;
    sb.push_back('{1'b1, 32'h1234_5678});
    cyc(); cyc(); cyc(); cyc();
    chk("rt_still_busy", {30'd0, current_state_vector}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    cyc();
    d_req = 1'b0; mem_ready = 1'b0;
    pop_check("rt");
    chk("rt_no_tmo", {31'd0, timeout_error}, 32'd0);
    cyc();

    // Load that times out.
    d_req = 1'b1; d_addr = 32'h0000_0300; mem_rdata = 32'hDEAD_BEEF;
    sb.push_back('{1'b1, 32'h0000_0000});
    cyc();
    n = 0;
    while (current_state_vector == 2'b01 && n < 20) begin
      n++;
      cyc();
    end
    chk("to_busy_cycles", n, 32'd4);
    chk("to_tmo_with_done", {31'd0, timeout_error}, 32'd1);
    chk("to_d_done", {31'd0, d_done}, 32'd1);
    d_req = 1'b0;
    pop_check("to");
    cyc();

    // Successful fetch afterwards: sticky error remains.
    if_req = 1'b1; if_addr = 32'h0000_0020;
    sb.push_back('{1'b0, 32'h0000_0013});
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
    cyc();
    if_req = 1'b0; mem_ready = 1'b0;
    pop_check("f2");
    chk("f2_tmo_sticky", {31'd0, timeout_error}, 32'd1);
    cyc();

    // Async reset during BUSY.
    if_req = 1'b1; if_addr = 32'h0000_0030;
    cyc();
    chk("rb_busy_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rb_async_drop", {31'd0, mem_req}, 32'd0);
    if_req = 1'b0;
    cyc();
    chk("rb_no_done", {31'd0, if_done}, 32'd0);
    rst = 1'b0;
    cyc();
    chk_all_zero("rb_after");

    // Tie out of reset with immediate re-requests: fetch, data, fetch, data.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0040;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080;
    for (int k = 0; k < 4; k++) begin
      logic        exp_data;
      logic [31:0] rd;
      exp_data = (k % 2) == 1;
      rd = 32'hA000_0000 + k;
      sb.push_back('{exp_data, rd});
      cyc();
      chk("rr_grant_busy", {30'd0, grant_vector}, exp_data ? 32'd2 : 32'd1);
      chk("rr_mem_addr", mem_addr, exp_data ? 32'h0000_0080 : 32'h0000_0040);
      mem_ready = 1'b1; mem_rdata = rd;
      cyc();
      mem_ready = 1'b0;
      chk("rr_grant_done", {30'd0, grant_vector}, exp_data ? 32'd2 : 32'd1);
      pop_check("rr");
      cyc();
      chk("rr_grant_idle", {30'd0, grant_vector}, 32'd0);
    end
    if_req = 1'b0; d_req = 1'b0;
    cyc(); cyc();
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the core's single unified memory port between the instruction-fetch path and the load/store data path of the multicycle core. The sequencer's fetch and memory-access states raise requests. The arbiter serialises them onto one memory handshake, using round-robin on ties. It returns read data and a one-cycle done pulse to the winner, and aborts any transaction whose memory response exceeds a cycle budget.

## Interface
- TIMEOUT, default 64: maximum BUSY cycles awaiting `mem_ready`. 0 disables timeout.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- if_req  in  1  fetch request; held until `if_done`
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched word
- if_done  out  1  fetch complete, one-cycle pulse
- d_req  in  1  data request; held until `d_done`
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte enables
- d_rdata  out  32  load word
- d_done  out  1  data complete, one-cycle pulse
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte enables
- mem_rdata  in  32  memory read data, valid with `mem_ready`
- mem_ready  in  1  memory completes the current request this cycle
- timeout_error  out  1  sticky flag; set on any timeout
- current_state_vector  out  2  IDLE = 00, BUSY = 01, DONE = 10
- grant_vector  out  2  bit0 = fetch owns port, bit1 = data owns port

## Operation
- FSM states are IDLE, BUSY and DONE. An illegal state encoding returns to IDLE.
- **IDLE**
  - No request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant the requester that was not granted last (`last_grant`).
  - On a grant, register the winner's address, we, wdata and wstrb into the `mem_*` outputs, update `last_grant`, and go to BUSY.
  - Fetch grants force `mem_we=0` and `mem_wstrb=0`.
- **BUSY**
  - `mem_req=1`; the `mem_*` outputs stay stable.
  - If `mem_ready=1`: capture `mem_rdata` into the winner's rdata register and go to DONE.
  - Else if TIMEOUT≠0 and the BUSY cycle count has reached TIMEOUT: set `timeout_error`, load 32'h0 into the winner's rdata register, and go to DONE.
- **DONE**
  - `mem_req=0`. Pulse the winner's done signal for exactly one cycle, then go to IDLE.
  - `grant_vector` stays set through DONE and clears in IDLE.
- rdata registers hold their value until the next completion for the same requester.
- Stores also overwrite `d_rdata` with `mem_rdata`; the value is don't-care to the requester.
- Requesters must drop `req` on the edge that ends their done cycle. A req still high in the following IDLE is treated as a new request.
- Requests are not cancellable. Deasserting req while in BUSY has no effect; the transaction completes.
- The timeout counter clears on entry to BUSY and saturates. Its width is clog2(TIMEOUT+1), minimum 1 bit.
- `timeout_error` clears only on `rst`.

## Timing
- Reset values:
  - State = IDLE, `last_grant` = data, so the first tie goes to fetch.
  - All outputs are 0: `mem_*`, both rdata registers, both done signals, `timeout_error`, `grant_vector`, and `current_state_vector`.
- Async reset mid-transaction: `mem_req` drops immediately. There is no done pulse and the transaction is lost.
- Latency, with req first seen in IDLE at cycle 0:
  - `mem_req` rises at cycle 1.
  - With `mem_ready` at cycle 1+N, done pulses at cycle 2+N.
  - Minimum req-to-done is 2 cycles, giving at most one transaction per 3 cycles.
- Timeout case: `mem_ready` stays low for TIMEOUT BUSY cycles. Done pulses the cycle after the last BUSY cycle, and `timeout_error` rises in that same cycle.
- `mem_ready` is ignored outside BUSY. `mem_ready` in the cycle the timeout fires wins: normal completion, no error.
- `mem_req` is registered and glitch-free.

## Test plan
- **Reset**
  - Stimulus: assert rst during BUSY.
  - Response: `mem_req`=0 asynchronously; all outputs 0 with state 00 after release; no done pulse.
- **Single fetch**
  - Stimulus: `if_addr`=0x0000_0010; `mem_ready` on the first BUSY cycle with `mem_rdata`=0x0051_3093.
  - Response: `mem_addr`=0x10 and `mem_we`=0 at cycle 1; `if_done` at cycle 2 with `if_rdata`=0x0051_3093.
- **Tie, round-robin**
  - Stimulus: `if_req` and `d_req` rise together out of reset; each requester re-requests immediately after its done.
  - Response: grant order is fetch, data, fetch, data; `grant_vector` alternates 01/10.
- **Store path**
  - Stimulus: `d_we`=1, `d_addr`=0x100, `d_wdata`=0xCAFE_F00D, `d_wstrb`=0011; `mem_ready` after 3 wait cycles.
  - Response: `mem_*` fields match and stay stable across all 4 BUSY cycles; `d_done` pulses once.
- **Timeout**
  - Stimulus: TIMEOUT=4; data load; `mem_ready` held low.
  - Response: 4 BUSY cycles; `d_done` with `d_rdata`=0; `timeout_error`=1 and still 1 after the next successful transaction.
- **Ready on the timeout cycle**
  - Stimulus: TIMEOUT=4; `mem_ready` on the 4th BUSY cycle with `mem_rdata`=0x1234_5678.
  - Response: normal completion with `d_rdata`=0x1234_5678; `timeout_error` stays 0.
